// File: rtl/fifo_pkg.sv
// Shared constants for the async FIFO read side: default widths and the
// buffer-count / pop-counter widths used by fifo_rd_stream and fifo_skid2.
package fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 3;
    localparam int CNT_W     = 2;
    localparam int RDCNT_W   = 16;

    typedef logic [CNT_W-1:0] buf_cnt_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port (rempty/rdata/rinc) plus the valid/ready output stream.
// The master modport is the drain stage, the slave modport is its environment.
interface fifo_rd_stream_if
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
);

    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;

    modport master (
        input  rempty, rdata, m_ready,
        output rinc, m_valid, m_data
    );

    modport slave (
        output rempty, rdata, m_ready,
        input  rinc, m_valid, m_data
    );

endinterface

// File: rtl/fifo_skid2.sv
// Two-entry head/tail output buffer; head is always the oldest word.
// Callers never push when full without popping, nor pop when empty.
module fifo_skid2
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [DSIZE-1:0] i_din,
    output logic [DSIZE-1:0] o_head,
    output buf_cnt_t         o_count
);

    logic [DSIZE-1:0] r_head;
    logic [DSIZE-1:0] r_tail;
    buf_cnt_t         r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (i_push) begin
                        r_head  <= i_din;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && !i_pop) begin
                        r_tail  <= i_din;
                        r_count <= 2'd2;
                    end else if (i_push && i_pop) begin
                        r_head  <= i_din;
                    end else if (i_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    // Tail moves forward on every pop; a simultaneous push refills it.
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_din;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/fifo_rd_stream.sv
// Async FIFO read-side drain stage: rempty/rinc/rdata to a registered valid/ready stream.
// Define FIFO_RD_STREAM_CNT_EN to add the 16-bit rd_count pop counter output.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    fifo_rd_stream_if.master       bus
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [RDCNT_W-1:0]     rd_count
`endif
);

    generate
        if (BUF_DEPTH != 2) begin : g_bad_depth
            $error("fifo_rd_stream: BUF_DEPTH must be 2");
        end
    endgenerate

    logic             r_arm;
    logic [DSIZE-1:0] w_head;
    buf_cnt_t         w_count;
    logic             w_valid;
    logic             w_pop;
    logic             w_rinc;

    // The upstream empty flag is not trustworthy in the first cycle after reset.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_arm <= 1'b0;
        end else begin
            r_arm <= 1'b1;
        end
    end

    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid & bus.m_ready;
    assign w_rinc  = rrst_n & r_arm & ~bus.rempty & ((w_count != 2'd2) | w_pop);

    fifo_skid2 #(
        .DSIZE (DSIZE)
    ) u_skid (
        .i_clk   (rclk),
        .i_rst_n (rrst_n),
        .i_push  (w_rinc),
        .i_pop   (w_pop),
        .i_din   (bus.rdata),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.rinc    = w_rinc;
    assign bus.m_valid = w_valid;
    assign bus.m_data  = w_head;

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [RDCNT_W-1:0] r_rd_count;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_rd_count <= '0;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + 1'b1;
        end
    end

    assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: upstream FIFO, output buffer and
// consumer are modelled with queues; every cycle checks rinc/m_valid/m_data.
module tb_fifo_rd_stream;

    logic rclk;
    logic rrst_n;

    fifo_rd_stream_if #(.DSIZE(8)) bus ();

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] rd_count;
`endif

    fifo_rd_stream #(
        .DSIZE     (8),
        .BUF_DEPTH (2)
    ) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .bus      (bus)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .rd_count (rd_count)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int errors = 0;
    int checks = 0;

    logic [7:0] src_q[$];
    logic [7:0] buf_q[$];
    logic [7:0] out_q[$];
    int         pop_tick_q[$];
    logic       model_arm = 1'b0;
    int         tick_no = 0;
    int         rinc_cnt = 0;
    longint     pop_total = 0;
    logic       last_rinc = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // One clock cycle: apply inputs, check combinational outputs, then advance the model.
    task automatic tick(input logic rst_v, input logic rdy);
        logic       exp_valid;
        logic       exp_pop;
        logic       exp_rinc;
        logic [7:0] word;
        rrst_n      = rst_v;
        bus.m_ready = rdy;
        bus.rempty  = (src_q.size() == 0);
        bus.rdata   = (src_q.size() != 0) ? src_q[0] : 8'h00;
        #1;
        exp_valid = (buf_q.size() != 0);
        exp_pop   = exp_valid & rdy;
        exp_rinc  = rst_v & model_arm & (src_q.size() != 0) & ((buf_q.size() < 2) | exp_pop);

        checks++;
        if (bus.m_valid !== exp_valid) begin
            errors++;
            $display("FAIL m_valid tick=%0d got %b want %b", tick_no, bus.m_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (bus.m_data !== buf_q[0]) begin
                errors++;
                $display("FAIL m_data tick=%0d got %h want %h", tick_no, bus.m_data, buf_q[0]);
            end
        end
        checks++;
        if (bus.rinc !== exp_rinc) begin
            errors++;
            $display("FAIL rinc tick=%0d got %b want %b", tick_no, bus.rinc, exp_rinc);
        end
        if (rst_v && prev_stall) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data) begin
                errors++;
                $display("FAIL stall_stable tick=%0d got v=%b d=%h want v=1 d=%h",
                         tick_no, bus.m_valid, bus.m_data, prev_data);
            end
        end
        last_rinc  = bus.rinc;
        if (bus.rinc === 1'b1) rinc_cnt++;
        prev_stall = rst_v & (bus.m_valid === 1'b1) & ~rdy;
        prev_data  = bus.m_data;

        @(posedge rclk);
        if (!rst_v) begin
            buf_q.delete();
            model_arm = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (exp_pop) begin
                word = buf_q.pop_front();
                out_q.push_back(word);
                pop_tick_q.push_back(tick_no);
                pop_total++;
            end
            if (exp_rinc) begin
                word = src_q.pop_front();
                buf_q.push_back(word);
            end
            model_arm = 1'b1;
        end
        tick_no++;
        #1;
    endtask

    task automatic clear_obs();
        out_q.delete();
        pop_tick_q.delete();
        rinc_cnt = 0;
    endtask

    task automatic test_reset();
        src_q.delete();
        src_q.push_back(8'hA5);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h want v=0 d=00", bus.m_valid, bus.m_data);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (last_rinc !== 1'b0) begin
            errors++;
            $display("FAIL first_cycle_rinc got %b want 0", last_rinc);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (last_rinc !== 1'b1) begin
            errors++;
            $display("FAIL second_cycle_rinc got %b want 1", last_rinc);
        end
        clear_obs();
        repeat (3) tick(1'b1, 1'b1);
        checks++;
        if (out_q.size() != 1 || out_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL reset_drain got n=%0d want n=1 word a5", out_q.size());
        end
    endtask

    task automatic test_stream_basic();
        clear_obs();
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        src_q.push_back(8'h33);
        repeat (6) tick(1'b1, 1'b1);
        checks++;
        if (out_q.size() != 3 || out_q[0] !== 8'h11 || out_q[1] !== 8'h22 || out_q[2] !== 8'h33) begin
            errors++;
            $display("FAIL basic_order got n=%0d want 11,22,33", out_q.size());
        end else begin
            checks++;
            if (pop_tick_q[2] - pop_tick_q[0] != 2) begin
                errors++;
                $display("FAIL basic_consecutive got span %0d want 2", pop_tick_q[2] - pop_tick_q[0]);
            end
        end
        checks++;
        if (rinc_cnt != 3) begin
            errors++;
            $display("FAIL basic_rinc_count got %0d want 3", rinc_cnt);
        end
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_valid got %b want 0", bus.m_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w[4];
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            w[i] = 8'($urandom);
            src_q.push_back(w[i]);
        end
        repeat (6) tick(1'b1, 1'b0);
        checks++;
        if (rinc_cnt != 2) begin
            errors++;
            $display("FAIL bp_rinc_count got %0d want 2", rinc_cnt);
        end
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== w[0]) begin
            errors++;
            $display("FAIL bp_hold got v=%b d=%h want v=1 d=%h", bus.m_valid, bus.m_data, w[0]);
        end
        repeat (4) tick(1'b1, 1'b1);
        checks++;
        if (out_q.size() != 4) begin
            errors++;
            $display("FAIL bp_throughput got %0d words want 4", out_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_q[i] !== w[i]) begin
                    errors++;
                    $display("FAIL bp_order idx=%0d got %h want %h", i, out_q[i], w[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int budget;
        clear_obs();
        for (int i = 0; i < 100; i++) src_q.push_back(8'(i));
        budget = 0;
        while (out_q.size() < 100 && budget < 2000) begin
            tick(1'b1, 1'($urandom_range(0, 1)));
            budget++;
        end
        checks++;
        if (out_q.size() != 100) begin
            errors++;
            $display("FAIL random_timeout got %0d words want 100", out_q.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== 8'(i)) begin
                errors++;
                $display("FAIL random_seq idx=%0d got %h want %h", i, out_q[i], 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        for (int i = 1; i <= 5; i++) src_q.push_back(8'(8'h40 + i));
        repeat (4) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid got %b want 0", bus.m_valid);
        end
        tick(1'b1, 1'b1);
        checks++;
        if (last_rinc !== 1'b0) begin
            errors++;
            $display("FAIL midreset_rinc got %b want 0", last_rinc);
        end
        repeat (6) tick(1'b1, 1'b1);
        checks++;
        if (out_q.size() != 3 || out_q[0] !== 8'h43 || out_q[1] !== 8'h44 || out_q[2] !== 8'h45) begin
            errors++;
            $display("FAIL midreset_restart got n=%0d want 43,44,45", out_q.size());
        end
    endtask

`ifdef FIFO_RD_STREAM_CNT_EN
    task automatic test_counter();
        int budget;
        tick(1'b0, 1'b0);
        checks++;
        if (rd_count !== 16'd0) begin
            errors++;
            $display("FAIL cnt_reset got %0d want 0", rd_count);
        end
        pop_total = 0;
        budget = 0;
        while (pop_total < 70000 && budget < 72000) begin
            while (src_q.size() < 4) src_q.push_back(8'($urandom));
            tick(1'b1, 1'b1);
            budget++;
        end
        out_q.delete();
        pop_tick_q.delete();
        checks++;
        if (rd_count !== 16'd4464 || pop_total != 70000) begin
            errors++;
            $display("FAIL cnt_wrap got %0d (pops %0d) want 4464", rd_count, pop_total);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (rd_count !== 16'd0) begin
            errors++;
            $display("FAIL cnt_rereset got %0d want 0", rd_count);
        end
    endtask
`endif

    initial begin
        rrst_n      = 1'b0;
        bus.rempty  = 1'b1;
        bus.rdata   = 8'h00;
        bus.m_ready = 1'b0;
        @(posedge rclk);
        #1;
        test_reset();
        test_stream_basic();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef FIFO_RD_STREAM_CNT_EN
        test_counter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
